// File: rtl/ss_bus_sequencer.sv
// ============================================================================
// Module      : ss_bus_sequencer
// Description : Savestate bus initiator. Walks responder addresses to stream state
//               out (save), stream it in (load) or strobe defaults (clear).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module ss_bus_sequencer #(
    parameter logic [7:0] FIRST_ADDR   = 8'h01,
    parameter logic [7:0] LAST_ADDR    = 8'h10,
    parameter int         READ_LATENCY = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_save,
    input  logic        start_load,
    input  logic        start_clear,
    output logic        busy,
    output logic        done,
    output logic        core_reset_n,
    output logic [31:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [31:0] wr_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    output logic [31:0] ss_bus_in,
    output logic [7:0]  ss_bus_addr,
    output logic        ss_bus_wren,
    output logic        ss_bus_reset_n,
    input  logic [31:0] ss_bus_out
);

    localparam logic [1:0] LAT_TARGET = 2'(READ_LATENCY);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_SETTLE = 3'd1,
        S_RD_PUSH   = 3'd2,
        S_WR_WAIT   = 3'd3,
        S_WR_STROBE = 3'd4,
        S_CLR       = 3'd5,
        S_FINISH    = 3'd6
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  addr_q, addr_d;
    logic [1:0]  lat_q, lat_d;
    logic        clr_q, clr_d;
    logic        hold_q, hold_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic [31:0] bus_in_q, bus_in_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            addr_q    <= 8'h00;
            lat_q     <= 2'd0;
            clr_q     <= 1'b0;
            hold_q    <= 1'b0;
            rd_data_q <= 32'h0;
            bus_in_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lat_q     <= lat_d;
            clr_q     <= clr_d;
            hold_q    <= hold_d;
            rd_data_q <= rd_data_d;
            bus_in_q  <= bus_in_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lat_d     = lat_q;
        clr_d     = clr_q;
        hold_d    = hold_q;
        rd_data_d = rd_data_q;
        bus_in_d  = bus_in_q;
        case (state_q)
            S_IDLE: begin
                if (start_clear) begin
                    state_d = S_CLR;
                    addr_d  = 8'h00;
                    clr_d   = 1'b0;
                    hold_d  = 1'b1;
                end else if (start_load) begin
                    state_d = S_WR_WAIT;
                    addr_d  = FIRST_ADDR;
                    hold_d  = 1'b1;
                end else if (start_save) begin
                    state_d = S_RD_SETTLE;
                    addr_d  = FIRST_ADDR;
                    lat_d   = 2'd0;
                    hold_d  = 1'b0;
                end
            end
            // One extra cycle beyond the latency so the capture flop sees settled data
            S_RD_SETTLE: begin
                if (lat_q == LAT_TARGET) begin
                    rd_data_d = ss_bus_out;
                    state_d   = S_RD_PUSH;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_RD_PUSH: begin
                if (rd_ready) begin
                    if (addr_q == LAST_ADDR) begin
                        state_d = S_FINISH;
                        addr_d  = 8'h00;
                    end else begin
                        state_d = S_RD_SETTLE;
                        addr_d  = addr_q + 8'd1;
                        lat_d   = 2'd0;
                    end
                end
            end
            S_WR_WAIT: begin
                if (wr_valid) begin
                    bus_in_d = wr_data;
                    state_d  = S_WR_STROBE;
                end
            end
            S_WR_STROBE: begin
                if (addr_q == LAST_ADDR) begin
                    state_d = S_FINISH;
                    addr_d  = 8'h00;
                end else begin
                    state_d = S_WR_WAIT;
                    addr_d  = addr_q + 8'd1;
                end
            end
            S_CLR: begin
                if (clr_q) begin
                    state_d = S_FINISH;
                end else begin
                    clr_d = 1'b1;
                end
            end
            // Core reset is released only after the done cycle
            S_FINISH: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                addr_d  = 8'h00;
                hold_d  = 1'b0;
            end
        endcase
    end

    assign busy           = (state_q != S_IDLE);
    assign done           = (state_q == S_FINISH);
    assign core_reset_n   = ~hold_q;
    assign rd_data        = rd_data_q;
    assign rd_valid       = (state_q == S_RD_PUSH);
    assign wr_ready       = (state_q == S_WR_WAIT);
    assign ss_bus_in      = bus_in_q;
    assign ss_bus_addr    = addr_q;
    assign ss_bus_wren    = (state_q == S_WR_STROBE);
    assign ss_bus_reset_n = (state_q != S_CLR);

endmodule

`default_nettype wire

// File: tb/tb_ss_bus_sequencer.sv
// ============================================================================
// Module      : tb_ss_bus_sequencer
// Description : Directed bench for ss_bus_sequencer with three modelled responders.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ss_bus_sequencer;

    logic        clk = 1'b0;
    logic        reset_n, start_save, start_load, start_clear;
    logic        busy, done, core_reset_n;
    logic [31:0] rd_data;
    logic        rd_valid, rd_ready;
    logic [31:0] wr_data;
    logic        wr_valid, wr_ready;
    logic [31:0] ss_bus_in;
    logic [7:0]  ss_bus_addr;
    logic        ss_bus_wren, ss_bus_reset_n;
    logic [31:0] ss_bus_out;

    always #5 clk = ~clk;

    ss_bus_sequencer #(
        .FIRST_ADDR  (8'h01),
        .LAST_ADDR   (8'h03),
        .READ_LATENCY(1)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start_save    (start_save),
        .start_load    (start_load),
        .start_clear   (start_clear),
        .busy          (busy),
        .done          (done),
        .core_reset_n  (core_reset_n),
        .rd_data       (rd_data),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .wr_data       (wr_data),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .ss_bus_in     (ss_bus_in),
        .ss_bus_addr   (ss_bus_addr),
        .ss_bus_wren   (ss_bus_wren),
        .ss_bus_reset_n(ss_bus_reset_n),
        .ss_bus_out    (ss_bus_out)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Responders: addr 1 is the prog timer (default downcounter 8'hFF), 2..3 default 0
    logic        preset;
    logic [31:0] mem [0:3];
    always @(posedge clk) begin
        if (preset) begin
            for (int i = 0; i < 4; i++) mem[i] <= 32'hA0 + i;
        end else if (!ss_bus_reset_n) begin
            mem[1] <= 32'hFF;
            mem[2] <= 32'h0;
            mem[3] <= 32'h0;
        end else if (ss_bus_wren && ss_bus_addr >= 8'd1 && ss_bus_addr <= 8'd3) begin
            mem[ss_bus_addr[1:0]] <= ss_bus_in;
        end
        ss_bus_out <= (ss_bus_addr >= 8'd1 && ss_bus_addr <= 8'd3) ? mem[ss_bus_addr[1:0]] : 32'h0;
    end

    int          done_cnt = 0, rstlow_cnt = 0, clr_addr_bad = 0, rd_n = 0, wr_n = 0;
    logic [31:0] rd_log [0:63];
    logic [7:0]  wa_log [0:63];
    logic [31:0] wd_log [0:63];
    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!ss_bus_reset_n) begin
            rstlow_cnt++;
            if (ss_bus_addr != 8'h00) clr_addr_bad++;
        end
        if (ss_bus_wren && wr_n < 64) begin
            wa_log[wr_n] = ss_bus_addr;
            wd_log[wr_n] = ss_bus_in;
            wr_n++;
        end
        if (rd_valid && rd_ready && rd_n < 64) begin
            rd_log[rd_n] = rd_data;
            rd_n++;
        end
    end

    task automatic pulse(input logic s, input logic l, input logic c);
        @(posedge clk); #1;
        start_save = s; start_load = l; start_clear = c;
        @(posedge clk); #1;
        start_save = 1'b0; start_load = 1'b0; start_clear = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (done !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk({tag, "_done_seen"}, 32'(k < 300), 32'd1);
    endtask

    task automatic wait_addr(input logic [7:0] a, input string tag);
        int k = 0;
        while (ss_bus_addr !== a && k < 300) begin @(negedge clk); k++; end
        chk({tag, "_addr_seen"}, 32'(k < 300), 32'd1);
    endtask

    task automatic send_word(input logic [31:0] d, input int gap);
        int k = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        wr_data  = d;
        wr_valid = 1'b1;
        while (wr_ready !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk("wr_handshake", 32'(k < 300), 32'd1);
        @(posedge clk); #1;
        wr_valid = 1'b0;
        wr_data  = 32'hDEAD_BEEF;
    endtask

    initial begin
        int d0, r0, w0, s0, hold_bad, k;
        logic [31:0] ld [0:2];
        ld[0] = 32'h0000_7F80; ld[1] = 32'h1; ld[2] = 32'h2;
        reset_n = 1'b0; preset = 1'b1;
        start_save = 1'b0; start_load = 1'b0; start_clear = 1'b0;
        rd_ready = 1'b0; wr_valid = 1'b0; wr_data = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_core_reset_n", core_reset_n, 1);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_wr_ready", wr_ready, 0);
        chk("rst_wren", ss_bus_wren, 0);
        chk("rst_bus_reset_n", ss_bus_reset_n, 1);
        chk("rst_addr", ss_bus_addr, 0);
        chk("rst_bus_in", ss_bus_in, 0);
        chk("rst_rd_data", rd_data, 0);
        @(posedge clk); #1;
        reset_n = 1'b1; preset = 1'b0;

        // Save with free-flowing sink
        rd_ready = 1'b1; d0 = done_cnt; r0 = rd_n;
        pulse(1'b1, 1'b0, 1'b0);
        chk("t1_busy_rise", busy, 1);
        chk("t1_first_addr", ss_bus_addr, 8'h01);
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            if (core_reset_n !== 1'b1) chk("t1_core_reset_n", core_reset_n, 1);
            @(negedge clk); k++;
        end
        chk("t1_done_seen", 32'(k < 300), 32'd1);
        chk("t1_core_at_done", core_reset_n, 1);
        @(negedge clk);
        chk("t1_busy_fall", busy, 0);
        chk("t1_done_fall", done, 0);
        chk("t1_words", rd_n - r0, 3);
        for (int i = 0; i < 3; i++) chk("t1_word", rd_log[r0 + i], 32'hA1 + i);
        chk("t1_done_pulses", done_cnt - d0, 1);

        // Save with back-pressure on word 2
        r0 = rd_n;
        pulse(1'b1, 1'b0, 1'b0);
        wait_addr(8'h02, "t2");
        rd_ready = 1'b0;
        k = 0;
        while (rd_valid !== 1'b1 && k < 300) begin @(negedge clk); k++; end
        chk("t2_valid_seen", 32'(k < 300), 32'd1);
        hold_bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (!(rd_valid === 1'b1 && rd_data === 32'hA2 && ss_bus_addr === 8'h02)) hold_bad++;
            @(negedge clk);
        end
        chk("t2_hold", hold_bad, 0);
        @(posedge clk); #1;
        rd_ready = 1'b1;
        wait_done("t2");
        @(negedge clk);
        chk("t2_words", rd_n - r0, 3);
        for (int i = 0; i < 3; i++) chk("t2_word", rd_log[r0 + i], 32'hA1 + i);

        // Load wins over a simultaneous save; save during busy is dropped
        d0 = done_cnt; r0 = rd_n; w0 = wr_n;
        pulse(1'b1, 1'b1, 1'b0);
        chk("t3_busy", busy, 1);
        chk("t3_core_low", core_reset_n, 0);
        chk("t3_wr_ready", wr_ready, 1);
        chk("t3_no_rd_valid", rd_valid, 0);
        @(negedge clk); start_save = 1'b1;
        @(negedge clk); start_save = 1'b0;
        send_word(ld[0], 1);
        send_word(ld[1], 3);
        send_word(ld[2], 0);
        wait_done("t3");
        chk("t3_core_at_done", core_reset_n, 0);
        @(negedge clk);
        chk("t3_core_after", core_reset_n, 1);
        chk("t3_busy_fall", busy, 0);
        chk("t3_wren_count", wr_n - w0, 3);
        for (int i = 0; i < 3; i++) begin
            chk("t3_wren_addr", wa_log[w0 + i], 8'(i + 1));
            chk("t3_wren_data", wd_log[w0 + i], ld[i]);
        end
        chk("t3_mem1", mem[1], 32'h0000_7F80);
        repeat (6) @(negedge clk);
        chk("t5_no_save", rd_n - r0, 0);
        chk("t5_one_done", done_cnt - d0, 1);

        // Clear, then read back defaults
        w0 = wr_n; s0 = rstlow_cnt;
        pulse(1'b0, 1'b0, 1'b1);
        chk("t4_core_low", core_reset_n, 0);
        chk("t4_bus_reset_low", ss_bus_reset_n, 0);
        wait_done("t4");
        @(negedge clk);
        chk("t4_reset_cycles", rstlow_cnt - s0, 2);
        chk("t4_no_wren", wr_n - w0, 0);
        chk("t4_addr_zero", clr_addr_bad, 0);
        r0 = rd_n;
        pulse(1'b1, 1'b0, 1'b0);
        wait_done("t4_rb");
        @(negedge clk);
        chk("t4_downcounter", rd_log[r0], 32'hFF);
        chk("t4_word2", rd_log[r0 + 1], 32'h0);

        // Reset during load word 2
        pulse(1'b0, 1'b1, 1'b0);
        send_word(32'h1234_5678, 0);
        wait_addr(8'h02, "t6");
        reset_n = 1'b0; d0 = done_cnt;
        @(posedge clk); #1;
        chk("t6_busy", busy, 0);
        chk("t6_done", done, 0);
        chk("t6_core", core_reset_n, 1);
        chk("t6_addr", ss_bus_addr, 0);
        chk("t6_wr_ready", wr_ready, 0);
        repeat (2) @(posedge clk); #1;
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("t6_no_done", done_cnt - d0, 0);
        chk("t6_partial1", mem[1], 32'h1234_5678);
        chk("t6_partial2", mem[2], 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
